grid_snapshot_reader: RTL
=========================

Name: grid_snapshot_reader

Overview:
- Reads the generation state of the cell array.
- On each generation tick, captures the flattened grid state vector into a shadow register.
- Streams the snapshot out one row per handshake, row 0 first, to a downstream display or UART consumer.
- Accumulates the live-cell population of the frame and reports it when the frame ends.

Parameters:
ROWS, 8, number of grid rows
COLS, 8, number of grid columns (cells per row)
CNT_W, $clog2(ROWS*COLS+1), width of live_count

Ports:
clk  in  1  system clock; all logic on its rising edge
Rst  in  1  synchronous, active-high reset
grid_state  in  ROWS*COLS  current cell states; cell (r,c) at bit r*COLS+c
gen_tick  in  1  one-cycle pulse; cells advanced a generation this cycle
row_data  out  COLS  snapshot row; bit c = cell (row_idx,c)
row_idx  out  $clog2(ROWS)  index of row on row_data
row_valid  out  1  row_data/row_idx valid
row_ready  in  1  consumer accepts row
row_last  out  1  high with row_valid when row_idx==ROWS-1
live_count  out  CNT_W  population of last completed frame
count_valid  out  1  one-cycle pulse; live_count updated
busy  out  1  frame capture/stream in progress
overrun  out  1  sticky: gen_tick dropped while busy

Behaviour:
- Clocking and reset: one clock, clk. Rst is synchronous and active-high.
- Reset state: FSM=IDLE; all outputs 0 (row_data, row_idx, row_valid, row_last, live_count, count_valid, busy, overrun); shadow and accumulator 0.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - gen_tick=1 at edge T: shadow<=grid_state, accumulator<=0, row_idx<=0, overrun<=0, go to STREAM.
  - From T+1: row_valid=1, busy=1.
  - Capture latency is 1 cycle; the snapshot is of grid_state sampled at edge T.
- STREAM:
  - row_data = shadow row row_idx, from registers only (no combinational path from grid_state).
  - Transfer occurs at an edge where row_valid&row_ready. On transfer, accumulator += popcount(row_data).
  - If row_idx<ROWS-1: row_idx++, and the next row is presented the following cycle (one row/cycle with ready held high).
  - If row_idx==ROWS-1: row_valid<=0, go to DONE.
  - With row_valid=1 and row_ready=0: row_data, row_idx and row_last stay stable indefinitely.
  - grid_state changes after capture never affect the stream.
  - gen_tick in STREAM: ignored for capture; overrun<=1.
- DONE (exactly one cycle):
  - count_valid=1; live_count = final accumulator (registered on the last transfer edge); busy=1.
  - gen_tick in DONE is accepted as a new capture (same actions as IDLE), next state STREAM; count_valid still pulses this cycle.
  - Otherwise go to IDLE, busy=0.
- live_count holds its value until the next frame completes.
- Width rules:
  - Accumulator is CNT_W bits and cannot overflow (max ROWS*COLS).
  - Row popcount is $clog2(COLS+1) bits, zero-extended.
- Simultaneous events: gen_tick and Rst in the same cycle → reset wins.
- Rst mid-STREAM: frame abandoned; row_valid=0 next cycle; no count_valid; live_count cleared.
- overrun clears only on Rst or on an accepted capture.

Decomposition:
- Shared package gol_pkg holds:
  - default ROWS/COLS constants;
  - the state enum (IDLE, STREAM, DONE);
  - a constant function for count widths, shared with the cell array top.
- One natural sub-module: row_popcount. Combinational COLS-bit population count, parameterised on COLS. Reusable by the neighbour-count logic.

Test Plan (ROWS=4, COLS=4):
1. grid_state=16'h8421, gen_tick at T, row_ready=1 → rows 4'h1,4'h2,4'h4,4'h8 with row_idx 0..3 at T+1..T+4; row_last only at T+4; count_valid at T+5 with live_count=4; busy=0 at T+6.
2. Same frame, row_ready=0 for 3 cycles while row_idx=1 → row_data=4'h2, row_idx=1 held stable; transfer on ready; final live_count=4.
3. Capture 16'h00F0, then drive grid_state=16'hFFFF from T+1 → streamed rows 4'h0,4'hF,4'h0,4'h0; live_count=4.
4. gen_tick during STREAM → overrun=1, stream contents unchanged; after DONE/IDLE, next gen_tick → overrun=0 one cycle later.
5. Rst asserted while row_idx=2 → next cycle row_valid=0, busy=0, live_count=0; count_valid never pulses.
6. grid_state=16'hFFFF, gen_tick asserted in the DONE cycle of the previous frame → count_valid pulses, new frame row_idx=0 valid the next cycle; that frame's live_count=16.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared constants, state encoding and width helpers for the cell-array blocks.
package gol_pkg;

  localparam int unsigned GOL_ROWS = 8;
  localparam int unsigned GOL_COLS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } gol_state_e;

  // Bits needed to hold a population count in the range 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/row_popcount.sv
// Combinational population count of one COLS-bit grid row.
module row_popcount
  import gol_pkg::*;
#(
  parameter  int unsigned COLS = GOL_COLS,
  localparam int unsigned PC_W = cnt_width(COLS)
) (
  input  logic [COLS-1:0] bits,
  output logic [PC_W-1:0] count_c
);

  // Sum the set bits of the row.
  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      count_c = count_c + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/grid_snapshot_reader.sv
// Captures the grid on a generation tick, streams it row by row through a
// valid/ready handshake and reports the frame's live-cell population.
module grid_snapshot_reader
  import gol_pkg::*;
#(
  parameter  int unsigned ROWS  = GOL_ROWS,
  parameter  int unsigned COLS  = GOL_COLS,
  parameter  int unsigned CNT_W = cnt_width(ROWS * COLS),
  localparam int unsigned IDX_W = idx_width(ROWS)
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic [ROWS*COLS-1:0]   grid_state,
  input  logic                   gen_tick,
  output logic [COLS-1:0]        row_data,
  output logic [IDX_W-1:0]       row_idx,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic                   row_last,
  output logic [CNT_W-1:0]       live_count,
  output logic                   count_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned PC_W  = cnt_width(COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  gol_state_e         state_q, state_nxt;
  logic [CELLS-1:0]   shadow_q, shadow_nxt;
  logic [CNT_W-1:0]   acc_q, acc_nxt;
  logic [COLS-1:0]    row_data_nxt;
  logic [IDX_W-1:0]   row_idx_nxt;
  logic               row_valid_nxt;
  logic               row_last_nxt;
  logic [CNT_W-1:0]   live_count_nxt;
  logic               count_valid_nxt;
  logic               busy_nxt;
  logic               overrun_nxt;

  logic [PC_W-1:0]    row_pc_c;
  logic [IDX_W-1:0]   idx_inc;
  logic [CNT_W-1:0]   acc_sum;

  // Select one row out of the flattened snapshot.
  function automatic logic [COLS-1:0] row_of(input logic [CELLS-1:0] s,
                                              input logic [IDX_W-1:0] i);
    return s[32'(i) * COLS +: COLS];
  endfunction

  // Population of the row currently presented to the consumer.
  row_popcount #(
    .COLS (COLS)
  ) u_row_popcount (
    .bits    (row_data),
    .count_c (row_pc_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state_q;
    shadow_nxt      = shadow_q;
    acc_nxt         = acc_q;
    row_data_nxt    = row_data;
    row_idx_nxt     = row_idx;
    row_valid_nxt   = row_valid;
    row_last_nxt    = row_last;
    live_count_nxt  = live_count;
    count_valid_nxt = 1'b0;
    busy_nxt        = busy;
    overrun_nxt     = overrun;
    idx_inc         = row_idx + IDX_W'(1);
    acc_sum         = acc_q + CNT_W'(row_pc_c);

    unique case (state_q)
      STREAM: begin
        if (gen_tick) begin
          overrun_nxt = 1'b1;
        end
        if (row_valid && row_ready) begin
          acc_nxt = acc_sum;
          if (row_idx == LAST_IDX) begin
            row_valid_nxt   = 1'b0;
            row_last_nxt    = 1'b0;
            live_count_nxt  = acc_sum;
            count_valid_nxt = 1'b1;
            state_nxt       = DONE;
          end else begin
            row_idx_nxt  = idx_inc;
            row_data_nxt = row_of(shadow_q, idx_inc);
            row_last_nxt = (idx_inc == LAST_IDX);
          end
        end
      end
      DONE: begin
        if (!gen_tick) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase

    // A tick is accepted as a new capture whenever no frame is streaming.
    if (gen_tick && (state_q != STREAM)) begin
      shadow_nxt    = grid_state;
      acc_nxt       = '0;
      row_idx_nxt   = '0;
      row_data_nxt  = grid_state[COLS-1:0];
      row_valid_nxt = 1'b1;
      row_last_nxt  = (ROWS == 1);
      busy_nxt      = 1'b1;
      overrun_nxt   = 1'b0;
      state_nxt     = STREAM;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      acc_q       <= '0;
      row_data    <= '0;
      row_idx     <= '0;
      row_valid   <= 1'b0;
      row_last    <= 1'b0;
      live_count  <= '0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      shadow_q    <= shadow_nxt;
      acc_q       <= acc_nxt;
      row_data    <= row_data_nxt;
      row_idx     <= row_idx_nxt;
      row_valid   <= row_valid_nxt;
      row_last    <= row_last_nxt;
      live_count  <= live_count_nxt;
      count_valid <= count_valid_nxt;
      busy        <= busy_nxt;
      overrun     <= overrun_nxt;
    end
  end

endmodule
